composite_video_timing: RTL and testbench

- Parametrised successor to the single-mode PAL state machine in the top level.
- Generates PAL or NTSC composite timing (runtime-selectable, switched only at frame boundaries) and drives a line-fetch address to the frame buffer BRAM.
- Outputs multi-level grayscale luma from the fetched line plus a sync flag; downstream logic maps these to the PWM threshold.
- Runs on the fast PLL clock.

---
 rtl/composite_video_timing.sv | 204 ++++++++++++++++++++
 tb/tb_composite_video_timing.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/composite_video_timing.sv
// PAL/NTSC composite timing generator: tick/line counters, per-line waveform
// classification and registered sync, luma, field and frame-buffer row address.
module composite_video_timing #(
    parameter int TICKS_PER_USEC = 159,
    parameter int PIXELS         = 300,
    parameter int GRAY_BITS      = 2,
    parameter int ACTIVE_LINES   = 512,
    parameter int BLANK_LINES    = 68
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode_i,
    input  logic [PIXELS*GRAY_BITS-1:0] line_data,
    output logic [9:0]                  line_addr,
    output logic                        out_sync,
    output logic [GRAY_BITS-1:0]        out_luma,
    output logic                        field,
    output logic                        frame_start,
    output logic                        mode_active
);
    localparam int T        = TICKS_PER_USEC;
    localparam int LINE_P_I = 64 * T;
    localparam int LINE_N_I = (127 * T) / 2;
    localparam int ACT_I    = (1195 * T) / 100;

    localparam logic [15:0] LINE_PAL  = 16'(LINE_P_I);
    localparam logic [15:0] LINE_NTSC = 16'(LINE_N_I);
    localparam logic [15:0] HALF_PAL  = 16'(LINE_P_I / 2);
    localparam logic [15:0] HALF_NTSC = 16'(LINE_N_I / 2);
    localparam logic [15:0] FP        = 16'((165 * T) / 100);
    localparam logic [15:0] HS        = 16'((470 * T) / 100);
    localparam logic [15:0] SS        = 16'((235 * T) / 100);
    localparam logic [15:0] ACT       = 16'(ACT_I);
    localparam logic [15:0] TPP_PAL   = 16'((LINE_P_I - ACT_I) / PIXELS);
    localparam logic [15:0] TPP_NTSC  = 16'((LINE_N_I - ACT_I) / PIXELS);
    localparam int          XW        = $clog2(PIXELS + 1);
    localparam logic [XW-1:0] PX_END  = XW'(PIXELS);
    localparam logic [10:0] Y_LO      = 11'(BLANK_LINES);
    localparam logic [10:0] Y_HI      = 11'(BLANK_LINES + ACTIVE_LINES);

    logic [15:0]          tick_r;
    logic [9:0]           line_r;
    logic                 mode_r;
    logic [XW-1:0]        px_r;
    logic [15:0]          div_r;

    logic                 mode_cur_s;
    logic [15:0]          line_len_s;
    logic [15:0]          half_s;
    logic [15:0]          tpp_s;
    logic [9:0]           last_line_s;
    logic                 active_s;
    logic                 odd_s;
    logic                 field_s;
    logic                 first_long_s;
    logic                 second_long_s;
    logic [9:0]           rel_s;
    logic [10:0]          y_s;
    logic                 in_win_s;
    logic [9:0]           addr_s;
    logic [15:0]          off_s;
    logic                 long_s;
    logic                 sync_s;
    logic [GRAY_BITS-1:0] luma_s;
    int                   px_base_s;

    // The mode is sampled only when the frame (re)starts at line 1 tick 0
    assign mode_cur_s  = (line_r == 10'd1 && tick_r == 16'd0) ? mode_i : mode_r;
    assign line_len_s  = mode_cur_s ? LINE_NTSC : LINE_PAL;
    assign half_s      = mode_cur_s ? HALF_NTSC : HALF_PAL;
    assign tpp_s       = mode_cur_s ? TPP_NTSC : TPP_PAL;
    assign last_line_s = mode_cur_s ? 10'd525 : 10'd625;

    // Tick/line counters, mode latch and pixel divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r <= 16'd0;
            line_r <= 10'd1;
            mode_r <= 1'b0;
            px_r   <= '0;
            div_r  <= 16'd0;
        end else begin
            mode_r <= mode_cur_s;
            if (tick_r == line_len_s - 16'd1) begin
                tick_r <= 16'd0;
                if (line_r == last_line_s) begin
                    line_r <= 10'd1;
                end else begin
                    line_r <= line_r + 10'd1;
                end
            end else begin
                tick_r <= tick_r + 16'd1;
                line_r <= line_r;
            end
            if (tick_r == ACT - 16'd1) begin
                px_r  <= '0;
                div_r <= 16'd0;
            end else if (px_r == PX_END) begin
                px_r  <= px_r;
                div_r <= div_r;
            end else if (div_r == tpp_s - 16'd1) begin
                px_r  <= px_r + XW'(1);
                div_r <= 16'd0;
            end else begin
                px_r  <= px_r;
                div_r <= div_r + 16'd1;
            end
        end
    end

    // Line classification: picture line (with field-relative row) or half-line sync pattern
    always_comb begin
        active_s      = 1'b0;
        odd_s         = 1'b0;
        first_long_s  = 1'b0;
        second_long_s = 1'b0;
        rel_s         = 10'd0;
        if (mode_cur_s == 1'b0) begin
            field_s = (line_r >= 10'd314);
            if (line_r >= 10'd6 && line_r <= 10'd310) begin
                active_s = 1'b1;
                odd_s    = 1'b1;
                rel_s    = line_r - 10'd6;
            end else if (line_r >= 10'd318 && line_r <= 10'd622) begin
                active_s = 1'b1;
                rel_s    = line_r - 10'd318;
            end else begin
                first_long_s  = (line_r <= 10'd3) || (line_r == 10'd314) || (line_r == 10'd315);
                second_long_s = (line_r <= 10'd2) || (line_r >= 10'd313 && line_r <= 10'd315);
            end
        end else begin
            field_s = (line_r >= 10'd264);
            if (line_r >= 10'd10 && line_r <= 10'd263) begin
                active_s = 1'b1;
                odd_s    = 1'b1;
                rel_s    = line_r - 10'd10;
            end else if (line_r >= 10'd273) begin
                active_s = 1'b1;
                rel_s    = line_r - 10'd273;
            end else begin
                first_long_s  = (line_r >= 10'd4 && line_r <= 10'd6) ||
                                (line_r >= 10'd267 && line_r <= 10'd269);
                second_long_s = first_long_s;
            end
        end
    end

    assign y_s      = {rel_s, odd_s};
    assign in_win_s = active_s && (y_s >= Y_LO) && (y_s < Y_HI);
    assign addr_s   = in_win_s ? 10'(y_s - Y_LO) : 10'd0;

    // Sync and luma level for the current tick
    always_comb begin
        sync_s    = 1'b0;
        luma_s    = '0;
        px_base_s = 0;
        if (tick_r >= half_s) begin
            off_s  = tick_r - half_s;
            long_s = second_long_s;
        end else begin
            off_s  = tick_r;
            long_s = first_long_s;
        end
        if (active_s) begin
            if (tick_r >= FP && tick_r < FP + HS) begin
                sync_s = 1'b1;
            end else if (tick_r >= ACT && px_r < PX_END && in_win_s) begin
                px_base_s = int'(px_r) * GRAY_BITS;
                luma_s    = line_data[px_base_s +: GRAY_BITS];
            end else begin
                luma_s = '0;
            end
        end else begin
            if (long_s) begin
                sync_s = (off_s < half_s - HS);
            end else begin
                sync_s = (off_s < SS);
            end
        end
    end

    // Registered outputs, one cycle behind the tick/line that decides them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sync    <= 1'b1;
            out_luma    <= '0;
            line_addr   <= 10'd0;
            field       <= 1'b0;
            frame_start <= 1'b0;
            mode_active <= 1'b0;
        end else begin
            out_sync    <= sync_s;
            out_luma    <= luma_s;
            field       <= field_s;
            frame_start <= (line_r == 10'd1 && tick_r == 16'd0);
            mode_active <= mode_cur_s;
            if (tick_r < FP) begin
                line_addr <= addr_s;
            end else begin
                line_addr <= line_addr;
            end
        end
    end
endmodule

// File: tb/tb_composite_video_timing.sv
// Randomized bench for composite_video_timing against a line-table reference model
// (scaled to one tick per microsecond so whole frames fit a short run).
module tb_composite_video_timing;
    localparam int T      = 1;
    localparam int PIXELS = 8;
    localparam int GB     = 2;
    localparam int ACTIVE = 512;
    localparam int BLANK  = 68;
    localparam int DW     = PIXELS * GB;
    localparam int LINE_P = 64 * T;
    localparam int LINE_N = (127 * T) / 2;
    localparam int FP     = (165 * T) / 100;
    localparam int HS     = (470 * T) / 100;
    localparam int SS     = (235 * T) / 100;
    localparam int ACT    = (1195 * T) / 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_i = 1'b0;
    logic [DW-1:0] line_data = '0;
    logic [9:0]    line_addr;
    logic          out_sync;
    logic [GB-1:0] out_luma;
    logic          field;
    logic          frame_start;
    logic          mode_active;

    composite_video_timing #(
        .TICKS_PER_USEC(T), .PIXELS(PIXELS), .GRAY_BITS(GB),
        .ACTIVE_LINES(ACTIVE), .BLANK_LINES(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .line_data(line_data),
        .line_addr(line_addr), .out_sync(out_sync), .out_luma(out_luma),
        .field(field), .frame_start(frame_start), .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_line, m_tick, cyc, last_fs;
    bit m_mode, fs_mode;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (line %0d tick %0d)", tag, obs, exp, m_line, m_tick);
        end
    endtask

    function automatic string half_kinds(input bit mode, input int line);
        if (!mode) begin
            if (line inside {1, 2, 314, 315}) return "LL";
            if (line == 3) return "LS";
            if (line == 313) return "SL";
            if (line inside {4, 5, 311, 312, 316, 317, [623:625]}) return "SS";
        end else begin
            if (line inside {[1:3], [7:9], [264:266], [270:272]}) return "SS";
            if (line inside {[4:6], [267:269]}) return "LL";
        end
        return "";
    endfunction

    function automatic void model_out(input bit mode, input int line, input int tick,
                                      input logic [DW-1:0] data, output bit sync, output int luma,
                                      output bit fld, output bit act, output int addr);
        string k;
        int half, tpp, h, off, first, y, x;
        bit in_win;
        half = (mode ? LINE_N : LINE_P) / 2;
        tpp  = ((mode ? LINE_N : LINE_P) - ACT) / PIXELS;
        k    = half_kinds(mode, line);
        fld  = mode ? (line >= 264) : (line >= 314);
        act  = (k.len() == 0);
        luma = 0;
        addr = 0;
        if (!act) begin
            h    = (tick >= half) ? 1 : 0;
            off  = tick - h * half;
            sync = (k[h] == "L") ? (off < half - HS) : (off < SS);
        end else begin
            if (!mode) first = (line <= 310) ? 6 : 318;
            else       first = (line <= 263) ? 10 : 273;
            y      = (line - first) * 2 + (fld ? 0 : 1);
            in_win = (y >= BLANK) && (y < BLANK + ACTIVE);
            addr   = in_win ? y - BLANK : 0;
            sync   = (tick >= FP) && (tick < FP + HS);
            if (in_win && tick >= ACT && tick < ACT + PIXELS * tpp) begin
                x    = (tick - ACT) / tpp;
                luma = int'(data[x * GB +: GB]);
            end
        end
    endfunction

    task automatic model_reset();
        m_line  = 1;
        m_tick  = 0;
        m_mode  = 1'b0;
        cyc     = 0;
        last_fs = -1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_sync"}, 32'(out_sync), 32'd1);
        check_val({tag, "_luma"}, 32'(out_luma), 32'd0);
        check_val({tag, "_addr"}, 32'(line_addr), 32'd0);
        check_val({tag, "_field"}, 32'(field), 32'd0);
        check_val({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // New random row and mode noise at each line start; line 1 keeps the chosen mode
    task automatic line_inputs();
        if (m_tick == 0) begin
            line_data = (m_line == 100) ? DW'({2'b10, {(DW - 4){1'b0}}, 2'b11}) : DW'($urandom);
            if (!m_mode && m_line >= 200) mode_i = 1'b1;
            else if (m_line >= 2) mode_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step();
        bit eff, e_sync, e_fld, e_act, e_fs;
        int e_luma, e_addr;
        eff  = (m_line == 1 && m_tick == 0) ? mode_i : m_mode;
        e_fs = (m_line == 1 && m_tick == 0);
        model_out(eff, m_line, m_tick, line_data, e_sync, e_luma, e_fld, e_act, e_addr);
        @(posedge clk);
        #1;
        cyc++;
        check_val("sync", 32'(out_sync), 32'(e_sync));
        check_val("luma", 32'(out_luma), 32'(e_luma));
        check_val("field", 32'(field), 32'(e_fld));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
        check_val("mode_active", 32'(mode_active), 32'(eff));
        if (e_act) check_val("line_addr", 32'(line_addr), 32'(e_addr));
        if (frame_start === 1'b1) begin
            if (last_fs >= 0)
                check_val("frame_period", 32'(cyc - last_fs), 32'(fs_mode ? 525 * LINE_N : 625 * LINE_P));
            last_fs = cyc;
            fs_mode = eff;
        end
        m_mode = eff;
        if (m_tick == (eff ? LINE_N : LINE_P) - 1) begin
            m_tick = 0;
            m_line = (m_line == (eff ? 525 : 625)) ? 1 : m_line + 1;
        end else begin
            m_tick++;
        end
    endtask

    initial begin
        int stop;
        model_reset();
        line_data = DW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;

        // Full PAL frame (mode request arrives at line 200), then NTSC into field two
        while (!(m_mode && m_line == 280)) begin
            line_inputs();
            step();
        end

        // Mid-line asynchronous resets, released into PAL then NTSC
        for (int r = 0; r < 2; r++) begin
            stop = $urandom_range(5, LINE_N - 2);
            do begin
                line_inputs();
                step();
            end while (m_tick != stop);
            rst = 1'b1;
            #1;
            check_reset("rst_async");
            @(posedge clk);
            #1;
            check_reset("rst_hold");
            mode_i = (r == 1);
            rst    = 1'b0;
            model_reset();
            repeat (3 * LINE_P + 5) begin
                line_inputs();
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
